// File: rtl/regfile_read_arbiter.sv
// Round-robin arbiter sharing one register-file read port between N_REQ requesters.
// Optional macro REGFILE_ARB_ZERO_REG_EN makes reads of register 31 return zero.
module regfile_read_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned n     = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [5*N_REQ-1:0] req_addr,
    output logic [N_REQ-1:0]   req_ready,
    output logic [4:0]         rf_select,
    input  logic [n-1:0]       rf_data,
    output logic [N_REQ-1:0]   rsp_valid,
    output logic [n-1:0]       rsp_data,
    input  logic [N_REQ-1:0]   rsp_ready
);

    localparam int unsigned TW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [TW-1:0] last;
    logic [TW-1:0] s1_tag;
    logic [TW-1:0] s2_tag;
    logic          s1_vld;
    logic          rsp_vld;

    logic          s2_free;
    logic          s1_adv;
    logic          accept_ok;
    logic          found;
    logic          accept;
    logic [TW-1:0] grant_idx;
    logic [4:0]    grant_addr;
    logic [n-1:0]  capture;

    assign s2_free   = !rsp_vld || rsp_ready[s2_tag];
    assign s1_adv    = s2_free;
    assign accept_ok = !s1_vld || s1_adv;

    // Search starts one past the last grant so every requester gets a turn.
    always_comb begin
        logic [TW-1:0] cand;
        found     = 1'b0;
        grant_idx = last;
        cand      = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            cand = TW'((32'(last) + k) % N_REQ);
            if (!found && req_valid[cand]) begin
                found     = 1'b1;
                grant_idx = cand;
            end
        end
    end

    assign accept     = found && accept_ok && reset_n;
    assign grant_addr = req_addr[5*grant_idx +: 5];

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        rsp_valid = '0;
        if (rsp_vld) begin
            rsp_valid[s2_tag] = 1'b1;
        end
    end

`ifdef REGFILE_ARB_ZERO_REG_EN
    assign capture = (rf_select == 5'd31) ? '0 : rf_data;
`else
    assign capture = rf_data;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rf_select <= '0;
            s1_tag    <= '0;
            s1_vld    <= 1'b0;
            s2_tag    <= '0;
            rsp_vld   <= 1'b0;
            rsp_data  <= '0;
            last      <= TW'(N_REQ - 1);
        end else begin
            if (accept) begin
                rf_select <= grant_addr;
                s1_tag    <= grant_idx;
                s1_vld    <= 1'b1;
                last      <= grant_idx;
            end else if (s1_adv) begin
                s1_vld <= 1'b0;
            end
            if (s1_adv) begin
                rsp_data <= capture;
                s2_tag   <= s1_tag;
                rsp_vld  <= s1_vld;
            end
        end
    end

endmodule
